// File: rtl/gc_sched_pkg.sv
// Shared tag encodings, run-state enum and push-decode helper for gc_stream_scheduler.
// The optional statistics counters are enabled with GC_SCHED_STATS_EN.
package gc_sched_pkg;

    localparam logic [2:0] TAG_NONE      = 3'b000;
    localparam logic [2:0] TAG_KEY       = 3'b001;
    localparam logic [2:0] TAG_TABLE     = 3'b010;
    localparam logic [2:0] TAG_MASK      = 3'b011;
    localparam int         TAG_LABEL_BIT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } gc_state_e;

    // bit0 = push (index0, data0), bit1 = push (index1, data1)
    function automatic logic [1:0] push_mask(input logic [2:0] tag);
        logic [1:0] m;
        m = 2'b00;
        if (tag[TAG_LABEL_BIT]) begin
            m = tag[1:0];
        end else begin
            case (tag)
                TAG_KEY, TAG_TABLE: m = 2'b11;
                TAG_MASK:           m = 2'b01;
                TAG_NONE:           m = 2'b00;
                default:            m = 2'b00;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/gc_sched_fifo.sv
// Dual-write, single-read FIFO; when both write ports fire, wd0 lands ahead of wd1.
// Callers must not push more than the free space reported through count.
module gc_sched_fifo
    import gc_sched_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic [W-1:0]               wd0,
    input  logic                       we1,
    input  logic [W-1:0]               wd1,
    input  logic                       re,
    output logic [W-1:0]               rd,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_wa1;
    logic [1:0]      w_nwr;
    logic            w_rd_en;

    // Second write address skips past the first word only when it is written too.
    always_comb begin
        w_wa1   = r_wr_ptr + AW'(we0);
        w_nwr   = {1'b0, we0} + {1'b0, we1};
        w_rd_en = re && (r_count != {CW{1'b0}});
    end

    // Storage array; contents are don't-care until pointed at by a valid count.
    always_ff @(posedge clk) begin
        if (we0) r_mem[r_wr_ptr] <= wd0;
        if (we1) r_mem[w_wa1]    <= wd1;
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_nwr);
            r_rd_ptr <= r_rd_ptr + AW'(w_rd_en);
            r_count  <= r_count + CW'(w_nwr) - CW'(w_rd_en);
        end
    end

    assign rd    = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/gc_stream_scheduler.sv
// Runs one GarbledCircuit pass and serialises its 0/1/2-word-per-cycle output onto a host stream.
// Define GC_SCHED_STATS_EN to add the stat_words / stat_stall / stat_drop counters.
module gc_stream_scheduler
    import gc_sched_pkg::*;
#(
    parameter int S     = 16,
    parameter int K     = 128,
    parameter int CC    = 1,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_start,
    output logic          gc_start,
    input  logic [2:0]    gc_tag,
    input  logic [S-1:0]  gc_cid,
    input  logic [S-1:0]  gc_index0,
    input  logic [S-1:0]  gc_index1,
    input  logic [K-1:0]  gc_data0,
    input  logic [K-1:0]  gc_data1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_tag,
    output logic [S-1:0]  out_cid,
    output logic [S-1:0]  out_index,
    output logic [K-1:0]  out_data,
    output logic          busy,
    output logic          done,
    output logic          overflow
`ifdef GC_SCHED_STATS_EN
    ,
    output logic [31:0]   stat_words,
    output logic [31:0]   stat_stall,
    output logic [15:0]   stat_drop
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]   tag;
        logic [S-1:0] cid;
        logic [S-1:0] index;
        logic [K-1:0] data;
    } entry_t;

    gc_state_e       r_state;
    gc_state_e       w_state_nxt;
    logic            r_cap_valid;
    logic [2:0]      r_tag;
    logic [S-1:0]    r_cid;
    logic [S-1:0]    r_idx0;
    logic [S-1:0]    r_idx1;
    logic [K-1:0]    r_d0;
    logic [K-1:0]    r_d1;
    logic            r_gc_start;
    logic            r_busy;
    logic            r_done;
    logic            r_overflow;
    logic            w_exit;
    logic [1:0]      w_mask;
    logic [1:0]      w_need;
    logic [CW-1:0]   w_free;
    logic            w_drop;
    logic            w_we0;
    logic            w_we1;
    logic            w_pop;
    logic            w_valid;
    logic [CW-1:0]   w_count;
    entry_t          w_wd0;
    entry_t          w_wd1;
    entry_t          w_head;

    // gc_* capture; r_cap_valid marks samples taken while the run was live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_valid <= 1'b0;
            r_tag       <= 3'b000;
            r_cid       <= {S{1'b0}};
            r_idx0      <= {S{1'b0}};
            r_idx1      <= {S{1'b0}};
            r_d0        <= {K{1'b0}};
            r_d1        <= {K{1'b0}};
        end else begin
            r_cap_valid <= (r_state == RUN);
            r_tag       <= gc_tag;
            r_cid       <= gc_cid;
            r_idx0      <= gc_index0;
            r_idx1      <= gc_index1;
            r_d0        <= gc_data0;
            r_d1        <= gc_data1;
        end
    end

    // Decode and all-or-nothing space check against start-of-cycle occupancy.
    always_comb begin
        w_exit = (r_state == RUN) && r_cap_valid && (r_cid == S'(CC));
        w_mask = 2'b00;
        if ((r_state == RUN) && r_cap_valid && !w_exit) begin
            w_mask = push_mask(r_tag);
        end else begin
            w_mask = 2'b00;
        end
        w_need = {1'b0, w_mask[0]} + {1'b0, w_mask[1]};
        w_free = CW'(DEPTH) - w_count;
        w_drop = (w_need != 2'b00) && (CW'(w_need) > w_free);
        w_we0  = w_mask[0] && !w_drop;
        w_we1  = w_mask[1] && !w_drop;
        w_wd0  = '{tag: r_tag, cid: r_cid, index: r_idx0, data: r_d0};
        w_wd1  = '{tag: r_tag, cid: r_cid, index: r_idx1, data: r_d1};
    end

    gc_sched_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .we0   (w_we0),
        .wd0   (w_wd0),
        .we1   (w_we1),
        .wd1   (w_wd1),
        .re    (w_pop),
        .rd    (w_head),
        .count (w_count)
    );

    // Head presentation; fields are forced to zero whenever nothing is queued.
    always_comb begin
        w_valid   = (w_count != {CW{1'b0}});
        w_pop     = w_valid && out_ready;
        out_valid = w_valid;
        if (w_valid) begin
            out_tag   = w_head.tag;
            out_cid   = w_head.cid;
            out_index = w_head.index;
            out_data  = w_head.data;
        end else begin
            out_tag   = 3'b000;
            out_cid   = {S{1'b0}};
            out_index = {S{1'b0}};
            out_data  = {K{1'b0}};
        end
    end

    // Run-sequencing state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; host_start is only honoured between runs.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (host_start) w_state_nxt = START; else w_state_nxt = IDLE;
            START:   w_state_nxt = RUN;
            RUN:     if (w_exit) w_state_nxt = DRAIN; else w_state_nxt = RUN;
            DRAIN:   if (!w_valid) w_state_nxt = DONE; else w_state_nxt = DRAIN;
            DONE:    if (host_start) w_state_nxt = START; else w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status flags registered from the next state so they align with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gc_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_gc_start <= (w_state_nxt == START);
            r_busy     <= (w_state_nxt == START) || (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_done     <= (w_state_nxt == DONE);
            if (w_state_nxt == START) r_overflow <= 1'b0;
            else if (w_drop)          r_overflow <= 1'b1;
        end
    end

    assign gc_start = r_gc_start;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

`ifdef GC_SCHED_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_stall;
    logic [15:0] r_stat_drop;

    // Saturating run statistics, cleared on entry to START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_words <= 32'h0000_0000;
            r_stat_stall <= 32'h0000_0000;
            r_stat_drop  <= 16'h0000;
        end else if (w_state_nxt == START) begin
            r_stat_words <= 32'h0000_0000;
            r_stat_stall <= 32'h0000_0000;
            r_stat_drop  <= 16'h0000;
        end else begin
            if (w_pop && (r_stat_words != 32'hFFFF_FFFF)) r_stat_words <= r_stat_words + 32'd1;
            if (w_valid && !out_ready && (r_stat_stall != 32'hFFFF_FFFF))
                r_stat_stall <= r_stat_stall + 32'd1;
            if (w_drop) begin
                if (r_stat_drop > (16'hFFFF - {14'd0, w_need})) r_stat_drop <= 16'hFFFF;
                else                                            r_stat_drop <= r_stat_drop + {14'd0, w_need};
            end
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
    assign stat_drop  = r_stat_drop;
`endif

endmodule

// File: tb/tb_gc_stream_scheduler.sv
// Directed bench for gc_stream_scheduler (S=16, K=128, CC=1, DEPTH=8).
module tb_gc_stream_scheduler;

    localparam int S = 16;
    localparam int K = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_start;
    logic          gc_start;
    logic [2:0]    gc_tag;
    logic [S-1:0]  gc_cid;
    logic [S-1:0]  gc_index0;
    logic [S-1:0]  gc_index1;
    logic [K-1:0]  gc_data0;
    logic [K-1:0]  gc_data1;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_tag;
    logic [S-1:0]  out_cid;
    logic [S-1:0]  out_index;
    logic [K-1:0]  out_data;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef GC_SCHED_STATS_EN
    logic [31:0]   stat_words;
    logic [31:0]   stat_stall;
    logic [15:0]   stat_drop;
`endif

    int checks = 0;
    int errors = 0;

    gc_stream_scheduler #(.S(S), .K(K), .CC(1), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_start (host_start),
        .gc_start   (gc_start),
        .gc_tag     (gc_tag),
        .gc_cid     (gc_cid),
        .gc_index0  (gc_index0),
        .gc_index1  (gc_index1),
        .gc_data0   (gc_data0),
        .gc_data1   (gc_data1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_cid    (out_cid),
        .out_index  (out_index),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
`ifdef GC_SCHED_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall),
        .stat_drop  (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_gc(input logic [2:0] tag, input logic [S-1:0] cid,
                            input logic [S-1:0] i0, input logic [S-1:0] i1,
                            input logic [K-1:0] d0, input logic [K-1:0] d1);
        gc_tag    = tag;
        gc_cid    = cid;
        gc_index0 = i0;
        gc_index1 = i1;
        gc_data0  = d0;
        gc_data1  = d1;
    endtask

    task automatic check_head(input string nm, input logic [2:0] tag,
                              input logic [S-1:0] idx, input logic [K-1:0] data);
        check({nm, ".valid"}, 256'(out_valid), 256'(1'b1));
        check({nm, ".tag"},   256'(out_tag),   256'(tag));
        check({nm, ".index"}, 256'(out_index), 256'(idx));
        check({nm, ".data"},  256'(out_data),  256'(data));
    endtask

    initial begin
        rst        = 1'b0;
        host_start = 1'b0;
        out_ready  = 1'b0;
        drive_gc(3'b000, 16'd0, 16'd0, 16'd0, 128'd0, 128'd0);
        tick();
        tick();
        check("rst.out_valid", 256'(out_valid), 256'(1'b0));
        check("rst.gc_start",  256'(gc_start),  256'(1'b0));
        check("rst.busy",      256'(busy),      256'(1'b0));
        check("rst.done",      256'(done),      256'(1'b0));
        check("rst.overflow",  256'(overflow),  256'(1'b0));
        check("rst.out_data",  256'(out_data),  256'(128'd0));
        rst = 1'b1;
        tick();

        // Start pulse
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check("start.gc_start", 256'(gc_start), 256'(1'b1));
        check("start.busy",     256'(busy),     256'(1'b1));
        tick();
        check("run.gc_start_one_cycle", 256'(gc_start), 256'(1'b0));
        check("run.busy",               256'(busy),     256'(1'b1));

        // Keys: two words on consecutive cycles, two-cycle latency
        out_ready = 1'b1;
        drive_gc(3'b001, 16'd0, 16'd1, 16'd2, 128'hA, 128'hB);
        tick();
        drive_gc(3'b000, 16'd0, 16'd0, 16'd0, 128'd0, 128'd0);
        check("key.latency_not_yet", 256'(out_valid), 256'(1'b0));
        tick();
        check_head("key.w0", 3'b001, 16'd1, 128'hA);
        check("key.w0.cid", 256'(out_cid), 256'(16'd0));
        tick();
        check_head("key.w1", 3'b001, 16'd2, 128'hB);
        tick();
        check("key.empty", 256'(out_valid), 256'(1'b0));

        // Labels: 100 -> 0 words, 101 -> data0, 110 -> data1, 111 -> both
        out_ready = 1'b0;
        drive_gc(3'b100, 16'd0, 16'h10, 16'h11, 128'h100, 128'h101);
        tick();
        drive_gc(3'b101, 16'd0, 16'd3, 16'h33, 128'h30, 128'h31);
        tick();
        drive_gc(3'b110, 16'd0, 16'h44, 16'd5, 128'h50, 128'h51);
        tick();
        drive_gc(3'b111, 16'd0, 16'd7, 16'd8, 128'h70, 128'h80);
        tick();
        drive_gc(3'b000, 16'd0, 16'd0, 16'd0, 128'd0, 128'd0);
        tick();
        tick();
        check_head("lbl.101", 3'b101, 16'd3, 128'h30);
        out_ready = 1'b1;
        tick();
        check_head("lbl.110", 3'b110, 16'd5, 128'h51);
        tick();
        check_head("lbl.111a", 3'b111, 16'd7, 128'h70);
        tick();
        check_head("lbl.111b", 3'b111, 16'd8, 128'h80);
        tick();
        check("lbl.empty", 256'(out_valid), 256'(1'b0));

        // Overflow: five table cycles into an 8-entry FIFO with no reads
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_gc(3'b010, 16'd0, 16'(2 * k), 16'(2 * k + 1),
                     128'(32'h200 + 2 * k), 128'(32'h201 + 2 * k));
            tick();
        end
        drive_gc(3'b000, 16'd0, 16'd0, 16'd0, 128'd0, 128'd0);
        check("ovf.before", 256'(overflow), 256'(1'b0));
        tick();
        check("ovf.set", 256'(overflow), 256'(1'b1));
        tick();
        check_head("ovf.head_stable", 3'b010, 16'd0, 128'h200);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check_head($sformatf("ovf.w%0d", j), 3'b010, 16'(j), 128'(32'h200 + j));
            tick();
        end
        check("ovf.only8", 256'(out_valid), 256'(1'b0));
        check("ovf.sticky", 256'(overflow), 256'(1'b1));

        // End of run with three words queued, host toggling ready
        out_ready = 1'b0;
        drive_gc(3'b001, 16'd0, 16'h40, 16'h41, 128'hC0, 128'hC1);
        tick();
        drive_gc(3'b011, 16'd0, 16'h42, 16'h99, 128'hC2, 128'hFF);
        tick();
        drive_gc(3'b000, 16'd1, 16'd0, 16'd0, 128'd0, 128'd0);
        tick();
        gc_cid = 16'd0;
        tick();
        check("drain.busy", 256'(busy), 256'(1'b1));
        check("drain.done", 256'(done), 256'(1'b0));
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check("drain.start_ignored", 256'(gc_start), 256'(1'b0));
        check_head("drain.w0", 3'b001, 16'h40, 128'hC0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_head("drain.w1", 3'b001, 16'h41, 128'hC1);
        tick();
        check_head("drain.w1_hold", 3'b001, 16'h41, 128'hC1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_head("drain.w2", 3'b011, 16'h42, 128'hC2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain.empty", 256'(out_valid), 256'(1'b0));
        tick();
        check("done.done",     256'(done),     256'(1'b1));
        check("done.busy",     256'(busy),     256'(1'b0));
        check("done.overflow", 256'(overflow), 256'(1'b1));
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check("restart.gc_start", 256'(gc_start), 256'(1'b1));
        check("restart.ovf_clr",  256'(overflow), 256'(1'b0));
        check("restart.done",     256'(done),     256'(1'b0));
        tick();

        // Reset mid-run with five words queued
        drive_gc(3'b001, 16'd0, 16'h60, 16'h61, 128'hD0, 128'hD1);
        tick();
        drive_gc(3'b001, 16'd0, 16'h62, 16'h63, 128'hD2, 128'hD3);
        tick();
        drive_gc(3'b011, 16'd0, 16'h64, 16'h65, 128'hD4, 128'hD5);
        tick();
        drive_gc(3'b000, 16'd0, 16'd0, 16'd0, 128'd0, 128'd0);
        tick();
        check_head("mrst.queued", 3'b001, 16'h60, 128'hD0);
        rst = 1'b0;
        #1;
        check("mrst.async_valid", 256'(out_valid), 256'(1'b0));
        check("mrst.async_busy",  256'(busy),      256'(1'b0));
        check("mrst.async_data",  256'(out_data),  256'(128'd0));
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mrst.post_valid0", 256'(out_valid), 256'(1'b0));
        check("mrst.post_busy",   256'(busy),      256'(1'b0));
        check("mrst.post_done",   256'(done),      256'(1'b0));
        tick();
        check("mrst.post_valid1", 256'(out_valid), 256'(1'b0));
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        check("mrst.idle_start", 256'(gc_start), 256'(1'b1));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
